// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param; the producer/consumer side uses master, the FIFO uses slave.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned DEPTH      = 1024
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  RD_EN;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  ERR_CLR;
    logic                  EMPTY;
    logic                  FULL;
    logic                  ALMOST_EMPTY;
    logic                  ALMOST_FULL;
    logic                  PROG_EMPTY;
    logic                  PROG_FULL;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;
    logic [CNT_W-1:0]      WORD_COUNT;

    modport master (
        output WR_EN, WR_DATA, RD_EN, ERR_CLR,
        input  RD_DATA, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               PROG_EMPTY, PROG_FULL, OVERFLOW, UNDERFLOW, WORD_COUNT
    );

    modport slave (
        input  WR_EN, WR_DATA, RD_EN, ERR_CLR,
        output RD_DATA, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               PROG_EMPTY, PROG_FULL, OVERFLOW, UNDERFLOW, WORD_COUNT
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read, registered
// occupancy flags and sticky overflow/underflow errors.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH        = 36,
    parameter int unsigned DEPTH             = 1024,
    parameter int unsigned FWFT              = 0,
    parameter int unsigned PROG_EMPTY_THRESH = 4,
    parameter int unsigned PROG_FULL_THRESH  = DEPTH - 6
) (
    input  logic               CLK,
    input  logic               RESET_N,
    sync_fifo_param_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    if ((DATA_WIDTH < 1) || (DATA_WIDTH > 72) ||
        (DEPTH < 16) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (FWFT > 1) ||
        (PROG_EMPTY_THRESH < 1) || (PROG_EMPTY_THRESH > DEPTH - 2) ||
        (PROG_FULL_THRESH < 2) || (PROG_FULL_THRESH > DEPTH - 1)) begin : g_param_check
        $error("%m: illegal sync_fifo_param parameter set");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0]      wptr_q, rptr_q, cnt_q;
    logic [CNT_W-1:0]      wptr_n, rptr_n, cnt_n;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_n;
    logic                  empty_q, full_q, aempty_q, afull_q, pempty_q, pfull_q;
    logic                  ovf_q, unf_q, ovf_n, unf_n;
    logic                  wr_acc_c, rd_acc_c;
    logic [ADDR_W-1:0]     head_next_addr;

    // Next-state pointers, read data and sticky errors
    always_comb begin
        wr_acc_c       = bus.WR_EN & ~full_q;
        rd_acc_c       = bus.RD_EN & ~empty_q;
        wptr_n         = wptr_q + CNT_W'(wr_acc_c);
        rptr_n         = rptr_q + CNT_W'(rd_acc_c);
        cnt_n          = wptr_n - rptr_n;
        head_next_addr = rptr_q[ADDR_W-1:0] + ADDR_W'(1);
        rd_data_n      = rd_data_q;
        ovf_n          = ovf_q;
        unf_n          = unf_q;

        if (bus.WR_EN && full_q)     ovf_n = 1'b1;
        else if (bus.ERR_CLR)        ovf_n = 1'b0;
        if (bus.RD_EN && empty_q)    unf_n = 1'b1;
        else if (bus.ERR_CLR)        unf_n = 1'b0;

        if (FWFT != 0) begin
            // Head word lives in rd_data_q; it comes from the write port when it is the word landing now
            if (wr_acc_c && (cnt_q == '0))
                rd_data_n = bus.WR_DATA;
            else if (rd_acc_c && wr_acc_c && (cnt_q == CNT_W'(1)))
                rd_data_n = bus.WR_DATA;
            else if (rd_acc_c && (cnt_q > CNT_W'(1)))
                rd_data_n = mem[head_next_addr];
        end else if (rd_acc_c) begin
            rd_data_n = mem[rptr_q[ADDR_W-1:0]];
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge CLK) begin
        if (wr_acc_c) mem[wptr_q[ADDR_W-1:0]] <= bus.WR_DATA;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            aempty_q  <= 1'b0;
            afull_q   <= 1'b0;
            pempty_q  <= 1'b1;
            pfull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_n;
            rptr_q    <= rptr_n;
            cnt_q     <= cnt_n;
            rd_data_q <= rd_data_n;
            empty_q   <= (cnt_n == '0);
            full_q    <= (cnt_n == CNT_W'(DEPTH));
            aempty_q  <= (cnt_n == CNT_W'(1));
            afull_q   <= (cnt_n == CNT_W'(DEPTH - 1));
            pempty_q  <= (cnt_n <= CNT_W'(PROG_EMPTY_THRESH));
            pfull_q   <= (cnt_n >= CNT_W'(PROG_FULL_THRESH));
            ovf_q     <= ovf_n;
            unf_q     <= unf_n;
        end
    end

    assign bus.RD_DATA      = rd_data_q;
    assign bus.EMPTY        = empty_q;
    assign bus.FULL         = full_q;
    assign bus.ALMOST_EMPTY = aempty_q;
    assign bus.ALMOST_FULL  = afull_q;
    assign bus.PROG_EMPTY   = pempty_q;
    assign bus.PROG_FULL    = pfull_q;
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = unf_q;
    assign bus.WORD_COUNT   = cnt_q;
endmodule
